// File: rtl/button_event_ctrl_if.sv
// Avalon-MM slave bus bundle for the push-button controller.
// The master drives address/control/write data, and the slave returns registered read data.
interface button_event_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/button_event_ctrl.sv
// Push-button controller: per-bit synchronizer, debouncer, press capture with W1C,
// interrupt mask and a registered level interrupt, all behind an Avalon-MM slave.
module button_event_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                 clk,
    input  logic                 reset_n,
    button_event_ctrl_if.slave   bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       ADDR_DATA = 2'd0;
    localparam logic [1:0]       ADDR_MASK = 2'd1;
    localparam logic [1:0]       ADDR_RSVD = 2'd2;
    localparam logic [1:0]       ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] press_s;
    logic [WIDTH-1:0] w1c_s;
    logic             wr_en_s;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             irq_q;
    logic             irq_d;
    logic             unused_wdata_s;

    // Upper write-data bits beyond WIDTH carry no meaning for any register.
    assign unused_wdata_s = ^bus.writedata;

    assign wr_en_s = bus.chipselect & bus.write;

    // Per-bit debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = {CNT_W{1'b0}};
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = {CNT_W{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Keys are active-low, so a press is the falling edge of the debounced level.
    assign press_s = stable_q & ~stable_d;

    // Register write decode for MASK and the EDGE clear strobe.
    always_comb begin
        w1c_s  = {WIDTH{1'b0}};
        mask_d = mask_q;
        if (wr_en_s) begin
            case (bus.address)
                ADDR_MASK: mask_d = bus.writedata[WIDTH-1:0];
                ADDR_EDGE: w1c_s  = bus.writedata[WIDTH-1:0];
                ADDR_DATA: mask_d = mask_q;
                ADDR_RSVD: mask_d = mask_q;
                default:   mask_d = mask_q;
            endcase
        end else begin
            w1c_s  = {WIDTH{1'b0}};
            mask_d = mask_q;
        end
    end

    // A press arriving with a clear of the same bit keeps the bit set.
    assign edge_d = (edge_q & ~w1c_s) | press_s;
    assign irq_d  = |(edge_q & mask_q);

    // Read mux, sampled every cycle regardless of chipselect; reads have no side effects.
    always_comb begin
        readdata_d = 32'd0;
        case (bus.address)
            ADDR_DATA: readdata_d[WIDTH-1:0] = ~stable_q;
            ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
            ADDR_RSVD: readdata_d            = 32'd0;
            ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
            default:   readdata_d            = 32'd0;
        endcase
    end

    // State and registered outputs; the synchronizer resets to the released level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= {WIDTH{1'b1}};
            sync2_q    <= {WIDTH{1'b1}};
            stable_q   <= {WIDTH{1'b1}};
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end
            edge_q     <= {WIDTH{1'b0}};
            mask_q     <= {WIDTH{1'b0}};
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            edge_q     <= edge_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
Avalon-MM slave controller for the push-button inputs. Per bit, it synchronizes and debounces the raw key lines and captures press events. It also holds a per-bit interrupt mask and drives a level interrupt to the HPS/Nios. It sits between the board KEY pins and the system interconnect, and replaces a bare read-only button port with debounced, event-driven access.

Parameters:
WIDTH, 4, number of button inputs (1..32).
DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a new level (10 ms at 50 MHz); minimum 2.
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
address  input  2  word address of the register.
chipselect  input  1  slave select.
write  input  1  write strobe; qualified by chipselect.
writedata  input  32  write data.
readdata  output  32  registered read data.
in_port  input  WIDTH  raw button levels; asynchronous; active-low (pressed = 0).
irq  output  1  level interrupt, active-high.

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset values:
  - sync flops: all 1s.
  - debounced level `stable`: all 1s (released).
  - debounce counters: 0.
  - edge_capture: 0.
  - irq_mask: 0.
  - readdata: 0.
  - irq: 0.
- Synchronizer: two-flop synchronizer per bit on in_port. The result is sync[i]; there are 2 cycles of latency before debounce.
- Debounce, per bit, independent:
  - If sync[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Any glitch back to the stable value restarts the count. The counter never wraps.
- Press detect: press[i] = stable[i] & ~next_stable[i]. This is the 1->0 transition of the debounced level and is asserted for one cycle. Release (0->1) captures nothing.
- Register map (word addresses):
  - 0 DATA (RO): {zero-ext, ~stable}. Reads 1 = pressed.
  - 1 MASK (RW): irq_mask[WIDTH-1:0]. Upper bits read 0.
  - 2 reserved: reads 0; writes ignored.
  - 3 EDGE (R/W1C): edge_capture[WIDTH-1:0]. Writing 1 to a bit clears it; writing 0 has no effect.
- Writes take effect on the clk edge where chipselect & write = 1. Writes to DATA are ignored.
- Reads:
  - readdata is registered every cycle from the address mux, giving 1-cycle read latency.
  - Unused upper bits are 0.
  - Reads have no side effects.
- Simultaneous W1C and new press on the same bit in the same cycle: the set wins, and the bit stays 1.
- A press on an already-set bit stays set; presses are not counted.
- irq <= |(edge_capture & irq_mask). It is registered, so it asserts 1 cycle after the capture or mask update and deasserts 1 cycle after the clear or mask.
- Masked bits still capture. Unmasking a pending bit raises irq on the next cycle.
- Reset asserted mid-debounce or mid-transaction: all state returns to reset values immediately and asynchronously. There is no spurious press after reset release if the key is held; the held key is debounced from the released state and then captured once.

Test Plan:
1. Run with DEBOUNCE_CYCLES=4. After reset, read DATA, MASK and EDGE: each returns 0x00000000 and irq=0. Hold in_port=4'b1111.
2. Drive in_port[0] low and hold it. DATA reads 0x1 exactly 2+4 cycles after the change. EDGE bit0 sets on that same edge. irq stays 0 because the mask is 0.
3. Bounce in_port[1] with pulses of 0 lasting 3 cycles, separated by 1-cycle highs, 5 times, then return high. DATA bit1 never sets and EDGE stays 0x0.
4. Write MASK=0x1 with EDGE bit0 pending: irq=1 one cycle later. Write EDGE=0x1: irq=0 one cycle later and EDGE reads 0x0.
5. Time a W1C of bit2 to the same cycle as a bit2 press capture. EDGE bit2 reads 1 afterwards and irq stays asserted if masked.
6. Assert reset_n=0 for 1 cycle while in_port[3] is held low mid-count. All registers read 0. After release, DATA bit3 sets after 6 cycles and EDGE reads 0x8 exactly once.
